exc_commit: RTL

Exception commit unit in the memory stage, directly upstream of the CP0 register file. It collects per-instruction exception flags and interrupt requests, picks the highest-priority cause, and issues a single-cycle commit to CP0 (cause, EPC source, bad address, delay-slot flag, ERET). It then flushes the pipeline and holds a PC redirect toward fetch until fetch accepts it.

---
 rtl/exc_commit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/exc_commit.sv
// exc_commit: exception commit unit for the memory stage.
//
// Collects the M-stage exception flags and a registered interrupt request,
// selects the highest-priority cause, and issues a single-cycle commit to CP0
// (trap or ERET). After a commit the pipeline is flushed and a PC redirect is
// held toward fetch until fetch accepts it.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   m_valid, m_pc, m_bd   M-stage instruction valid, PC, delay-slot flag
//   m_exc_*               per-instruction exception flags
//   m_mem_addr            data address of the M instruction
//   m_eret                M instruction is ERET
//   cp0_interrupt         interrupt request from CP0
//   cp0_epc               current EPC, used as the ERET redirect target
//   redir_ready           fetch accepts the redirect
//   cp0_*                 commit outputs toward CP0 (combinational)
//   m_kill, flush         suppress M side effects / invalidate F..M
//   redir_valid, redir_pc redirect request toward fetch (registered)
//   trap_count            number of taken traps, wraps
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting M instructions; a trap or ERET commits this cycle
// REDIR | flushing and holding redir_pc until fetch takes it

module exc_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_valid,
  input  logic [31:0]      m_pc,
  input  logic             m_bd,
  input  logic             m_exc_if_adel,
  input  logic             m_exc_ri,
  input  logic             m_exc_ov,
  input  logic             m_exc_sys,
  input  logic             m_exc_bp,
  input  logic             m_exc_adel,
  input  logic             m_exc_ades,
  input  logic [31:0]      m_mem_addr,
  input  logic             m_eret,
  input  logic             cp0_interrupt,
  input  logic [31:0]      cp0_epc,
  input  logic             redir_ready,
  output logic             cp0_exception,
  output logic [5:0]       cp0_exc_code,
  output logic [31:0]      cp0_exc_pc,
  output logic             cp0_in_delay_slot,
  output logic             cp0_is_bad_addr,
  output logic [31:0]      cp0_bad_addr,
  output logic             cp0_eret,
  output logic             m_kill,
  output logic             flush,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  output logic [CNT_W-1:0] trap_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

  state_t           state;
  logic             int_req;
  logic [31:0]      redir_pc_q;
  logic [CNT_W-1:0] trap_cnt_q;

  logic             live;
  logic             trap;
  logic             eret_commit;
  logic             commit;
  logic [5:0]       code;
  logic             bad_en;
  logic [31:0]      bad_val;

  // Holding reset also masks the combinational commit path so nothing leaks
  // to CP0 while the block is being reset.
  assign live = m_valid & (state == IDLE) & ~reset;

  always_comb begin
    trap    = 1'b0;
    code    = 6'd0;
    bad_en  = 1'b0;
    bad_val = 32'd0;
    if (live) begin
      trap = 1'b1;
      if (int_req) begin
        code = 6'd0;
      end else if (m_exc_if_adel) begin
        code    = 6'd4;
        bad_en  = 1'b1;
        bad_val = m_pc;
      end else if (m_exc_ri) begin
        code = 6'd10;
      end else if (m_exc_ov) begin
        code = 6'd12;
      end else if (m_exc_sys) begin
        code = 6'd8;
      end else if (m_exc_bp) begin
        code = 6'd9;
      end else if (m_exc_adel) begin
        code    = 6'd4;
        bad_en  = 1'b1;
        bad_val = m_mem_addr;
      end else if (m_exc_ades) begin
        code    = 6'd5;
        bad_en  = 1'b1;
        bad_val = m_mem_addr;
      end else begin
        trap = 1'b0;
      end
    end
  end

  assign eret_commit = live & ~trap & m_eret;
  assign commit      = trap | eret_commit;

  assign cp0_exception     = trap;
  assign cp0_exc_code      = trap ? code : 6'd0;
  assign cp0_exc_pc        = trap ? m_pc : 32'd0;
  assign cp0_in_delay_slot = trap & m_bd;
  assign cp0_is_bad_addr   = bad_en;
  assign cp0_bad_addr      = bad_val;
  assign cp0_eret          = eret_commit;
  assign m_kill            = commit;
  assign flush             = commit | (state == REDIR);
  assign redir_valid       = (state == REDIR);
  assign redir_pc          = redir_pc_q;
  assign trap_count        = trap_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      redir_pc_q <= 32'd0;
      trap_cnt_q <= '0;
    end else begin
      // Registered to break the loop through CP0 Status.EXL; cleared on the
      // commit cycle so one request cannot be committed twice back to back.
      int_req <= cp0_interrupt & ~commit;
      case (state)
        IDLE: begin
          if (trap) begin
            state      <= REDIR;
            redir_pc_q <= EXC_VECTOR;
            trap_cnt_q <= trap_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (eret_commit) begin
            state      <= REDIR;
            redir_pc_q <= cp0_epc;
          end
        end
        REDIR: begin
          if (redir_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
